mano_timing_control_unit: RTL and testbench

- Control sequencer for the basic-computer datapath.
- Owns the sequence counter (SC), timing decode T[7:0], opcode decode D[7:0], indirect flip-flop I and start/stop flip-flop S.
- Issues per-cycle register, memory and bus strobes for fetch, decode, indirect and memory-reference execution.
- The DR load/increment terms (LD = T4·(D0|D1|D2|D6), INC = D6·T5) are generated here alongside all other strobes.

---
 rtl/mano_timing_control_unit.sv | 173 +++++++++++++++++
 tb/tb_mano_timing_control_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mano_timing_control_unit.sv
// Timing and control sequencer for the basic computer: sequence counter, T/D decode,
// I and S flip-flops, and the per-cycle register, memory and bus strobes.
module mano_timing_control_unit #(
  parameter int unsigned ADDR_W       = 12,
  parameter bit          RUN_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W+3:0] ir,
  input  logic              dr_zero,
  input  logic              start,
  output logic [7:0]        T,
  output logic [7:0]        D,
  output logic              i_flag,
  output logic              running,
  output logic              ar_ld,
  output logic              ar_inc,
  output logic              pc_ld,
  output logic              pc_inc,
  output logic              ir_ld,
  output logic              dr_ld,
  output logic              dr_inc,
  output logic              ac_and,
  output logic              ac_add,
  output logic              ac_ld,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [2:0]        bus_sel,
  output logic              rr_exec,
  output logic              io_exec
);

  typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} run_state_t;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_MEM  = 3'd7
  } bus_src_t;

  run_state_t state, state_nxt;
  logic [2:0] sc;
  logic       i_reg;
  logic       sc_clr;
  logic       halt;
  bus_src_t   bus_src;
  logic       unused_ir_bits;

  assign unused_ir_bits = ^ir[ADDR_W-1:1];

  assign running = (state == RUNNING);
  assign i_flag  = i_reg;
  assign T       = running ? (8'd1 << sc) : '0;
  assign D       = running ? (8'd1 << ir[ADDR_W+2:ADDR_W]) : '0;
  assign bus_sel = bus_src;
  assign halt    = rr_exec & ir[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc    <= '0;
      i_reg <= 1'b0;
      if (RUN_ON_RESET) state <= RUNNING;
      else              state <= STOPPED;
    end else begin
      state <= state_nxt;
      // Leaving STOPPED keeps SC at 0 so T0 is the first cycle after start.
      if (running && !sc_clr) sc <= sc + 3'd1;
      else                    sc <= '0;
      if (T[2]) i_reg <= ir[ADDR_W+3];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STOPPED: if (start) state_nxt = RUNNING;
      RUNNING: if (halt)  state_nxt = STOPPED;
      default: state_nxt = STOPPED;
    endcase
  end

  always_comb begin
    ar_ld   = 1'b0;
    ar_inc  = 1'b0;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    ir_ld   = 1'b0;
    dr_ld   = 1'b0;
    dr_inc  = 1'b0;
    ac_and  = 1'b0;
    ac_add  = 1'b0;
    ac_ld   = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    rr_exec = 1'b0;
    io_exec = 1'b0;
    sc_clr  = 1'b0;
    bus_src = BUS_NONE;
    // Gating on rst drops every strobe the instant reset rises, even while S stays 1.
    if (running && !rst) begin
      if (T[0]) begin
        bus_src = BUS_PC;
        ar_ld   = 1'b1;
      end
      if (T[1]) begin
        mem_rd  = 1'b1;
        bus_src = BUS_MEM;
        ir_ld   = 1'b1;
        pc_inc  = 1'b1;
      end
      if (T[2]) begin
        bus_src = BUS_IR;
        ar_ld   = 1'b1;
      end
      if (T[3]) begin
        if (D[7]) begin
          sc_clr  = 1'b1;
          rr_exec = !i_reg;
          io_exec = i_reg;
        end else if (i_reg) begin
          mem_rd  = 1'b1;
          bus_src = BUS_MEM;
          ar_ld   = 1'b1;
        end
      end
      if (T[4]) begin
        if (D[0] || D[1] || D[2] || D[6]) begin
          mem_rd  = 1'b1;
          bus_src = BUS_MEM;
          dr_ld   = 1'b1;
        end
        if (D[3]) begin
          bus_src = BUS_AC;
          mem_wr  = 1'b1;
          sc_clr  = 1'b1;
        end
        if (D[4]) begin
          bus_src = BUS_AR;
          pc_ld   = 1'b1;
          sc_clr  = 1'b1;
        end
        if (D[5]) begin
          bus_src = BUS_PC;
          mem_wr  = 1'b1;
          ar_inc  = 1'b1;
        end
      end
      if (T[5]) begin
        ac_and = D[0];
        ac_add = D[1];
        ac_ld  = D[2];
        dr_inc = D[6];
        if (D[0] || D[1] || D[2]) sc_clr = 1'b1;
        if (D[5]) begin
          bus_src = BUS_AR;
          pc_ld   = 1'b1;
          sc_clr  = 1'b1;
        end
      end
      if (T[6] && D[6]) begin
        bus_src = BUS_DR;
        mem_wr  = 1'b1;
        pc_inc  = dr_zero;
        sc_clr  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mano_timing_control_unit.sv
// Bench for mano_timing_control_unit: per-cycle comparison against an instruction-level
// model of the basic-computer control flow, plus hand-computed spot checks.
module tb_mano_timing_control_unit;

  typedef struct packed {
    logic ar_ld, ar_inc, pc_ld, pc_inc, ir_ld, dr_ld, dr_inc;
    logic ac_and, ac_add, ac_ld, mem_rd, mem_wr, rr_exec, io_exec;
    logic [2:0] bus_sel;
  } strb_t;

  logic        clk = 1'b0;
  logic        rst, dr_zero, start;
  logic [15:0] ir;
  logic [7:0]  T, D;
  logic        i_flag, running;
  logic        ar_ld, ar_inc, pc_ld, pc_inc, ir_ld, dr_ld, dr_inc;
  logic        ac_and, ac_add, ac_ld, mem_rd, mem_wr, rr_exec, io_exec;
  logic [2:0]  bus_sel;
  strb_t       dut_s;

  int n_cmp = 0;
  int n_bad = 0;

  bit m_run;
  int m_k;
  bit m_i;

  logic [7:0] hT[0:7];
  strb_t      hs[0:7];

  mano_timing_control_unit #(.ADDR_W(12), .RUN_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .ir(ir), .dr_zero(dr_zero), .start(start),
    .T(T), .D(D), .i_flag(i_flag), .running(running),
    .ar_ld(ar_ld), .ar_inc(ar_inc), .pc_ld(pc_ld), .pc_inc(pc_inc), .ir_ld(ir_ld),
    .dr_ld(dr_ld), .dr_inc(dr_inc), .ac_and(ac_and), .ac_add(ac_add), .ac_ld(ac_ld),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .bus_sel(bus_sel),
    .rr_exec(rr_exec), .io_exec(io_exec)
  );

  always #5 clk = ~clk;

  assign dut_s = {ar_ld, ar_inc, pc_ld, pc_inc, ir_ld, dr_ld, dr_inc,
                  ac_and, ac_add, ac_ld, mem_rd, mem_wr, rr_exec, io_exec, bus_sel};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Cycles per instruction: fetch+decode+T3 is 4, plus the execute phase.
  function automatic int instr_len(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd2, 3'd5: instr_len = 6;
      3'd3, 3'd4:             instr_len = 5;
      3'd6:                   instr_len = 7;
      default:                instr_len = 4;
    endcase
  endfunction

  // Register-transfer table of the basic computer, one row per (instruction, step).
  function automatic strb_t exp_strb(input logic [2:0] op, input bit ind, input int k, input bit dz);
    strb_t s = '0;
    case (k)
      0: begin s.ar_ld = 1'b1; s.bus_sel = 3'd2; end
      1: begin s.mem_rd = 1'b1; s.bus_sel = 3'd7; s.ir_ld = 1'b1; s.pc_inc = 1'b1; end
      2: begin s.ar_ld = 1'b1; s.bus_sel = 3'd5; end
      3: if (op == 3'd7) begin
           s.rr_exec = !ind;
           s.io_exec = ind;
         end else if (ind) begin
           s.mem_rd = 1'b1; s.bus_sel = 3'd7; s.ar_ld = 1'b1;
         end
      4: case (op)
           3'd0, 3'd1, 3'd2, 3'd6: begin s.mem_rd = 1'b1; s.bus_sel = 3'd7; s.dr_ld = 1'b1; end
           3'd3: begin s.bus_sel = 3'd4; s.mem_wr = 1'b1; end
           3'd4: begin s.bus_sel = 3'd1; s.pc_ld = 1'b1; end
           3'd5: begin s.bus_sel = 3'd2; s.mem_wr = 1'b1; s.ar_inc = 1'b1; end
           default: ;
         endcase
      5: case (op)
           3'd0: s.ac_and = 1'b1;
           3'd1: s.ac_add = 1'b1;
           3'd2: s.ac_ld  = 1'b1;
           3'd5: begin s.bus_sel = 3'd1; s.pc_ld = 1'b1; end
           3'd6: s.dr_inc = 1'b1;
           default: ;
         endcase
      6: if (op == 3'd6) begin s.bus_sel = 3'd3; s.mem_wr = 1'b1; s.pc_inc = dz; end
      default: ;
    endcase
    return s;
  endfunction

  always @(negedge clk) begin
    logic [2:0] op;
    strb_t      es;
    bit         halt;
    if (rst) begin
      m_run = 1'b1;
      m_k   = 0;
      m_i   = 1'b0;
    end
    op = ir[14:12];
    es = (m_run && !rst) ? exp_strb(op, m_i, m_k, dr_zero) : '0;
    check("T",       T,       m_run ? (32'd1 << m_k) : 32'd0);
    check("D",       D,       m_run ? (32'd1 << op)  : 32'd0);
    check("i_flag",  i_flag,  m_i);
    check("running", running, m_run);
    check("strobes", dut_s,   es);
    check("rd_wr_excl", mem_rd & mem_wr, 0);
    check("one_load", ($countones({ar_ld, pc_ld, ir_ld, dr_ld}) > 1), 0);
    if (!rst) begin
      if (m_run) begin
        if (m_k == 2) m_i = ir[15];
        halt = (m_k == 3) && (op == 3'd7) && !m_i && ir[0];
        if (m_k == instr_len(op) - 1) m_k = 0;
        else                          m_k++;
        if (halt) m_run = 1'b0;
      end else if (start) begin
        m_run = 1'b1;
        m_k   = 0;
      end
    end
  end

  // Entered and left at posedge+1; records each cycle's outputs for spot checks.
  task automatic run_instr(input logic [15:0] v, input bit dz, input int n);
    ir      = v;
    dr_zero = dz;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hT[i] = T;
      hs[i] = dut_s;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] walk[0:5];
    walk = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    rst = 1'b1; start = 1'b0; dr_zero = 1'b0; ir = 16'h2ABC;
    repeat (2) @(negedge clk);
    check("rst_T", T, 8'h01);
    check("rst_strobes", dut_s, 0);
    check("rst_i_flag", i_flag, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(16'h2ABC, 1'b0, 6);
    for (int i = 0; i < 6; i++) check("lda_T_walk", hT[i], walk[i]);
    check("lda_dr_ld_T4", hs[4].dr_ld, 1);
    check("lda_ac_ld_T5", hs[5].ac_ld, 1);

    run_instr(16'hE123, 1'b1, 7);
    check("lda_next_T0", hT[0], 8'h01);
    check("isz_ind_T3", {hs[3].mem_rd, hs[3].ar_ld, hs[3].bus_sel}, 5'b11_111);
    check("isz_dr_ld_T4", hs[4].dr_ld, 1);
    check("isz_dr_inc_T5", hs[5].dr_inc, 1);
    check("isz_T6", {hs[6].mem_wr, hs[6].bus_sel, hs[6].pc_inc}, 5'b1_011_1);
    run_instr(16'hE123, 1'b0, 7);
    check("isz_nz_pc_inc", hs[6].pc_inc, 0);

    run_instr(16'h5040, 1'b0, 6);
    check("bsa_T4", {hs[4].mem_wr, hs[4].bus_sel, hs[4].ar_inc}, 5'b1_010_1);
    check("bsa_T5", {hs[5].pc_ld, hs[5].bus_sel}, 4'b1_001);

    start = 1'b1;
    run_instr(16'h4123, 1'b0, 5);
    start = 1'b0;
    check("bsa_len6", hT[0], 8'h01);
    check("bun_T4", {hs[4].pc_ld, hs[4].bus_sel}, 4'b1_001);

    for (int ind = 0; ind < 2; ind++)
      for (int op = 0; op < 7; op++) begin
        logic [15:0] v;
        v = {ind[0], op[2:0], 12'h0A5};
        run_instr(v, ind[0] ^ op[0], instr_len(op[2:0]));
      end
    run_instr(16'h7002, 1'b0, 4);
    run_instr(16'hF001, 1'b0, 4);

    run_instr(16'h7001, 1'b0, 4);
    check("hlt_rr_exec", hs[3].rr_exec, 1);
    run_instr(16'h7001, 1'b0, 3);
    for (int i = 0; i < 3; i++) begin
      check("halted_T", hT[i], 8'h00);
      check("halted_strobes", hs[i], 0);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_instr(16'h2ABC, 1'b0, 6);
    check("restart_T0", hT[0], 8'h01);

    ir = 16'h7001;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("hlt_beats_start", running, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    run_instr(16'h9234, 1'b0, 5);
    check("add_ind_i_flag", i_flag, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_T", T, 8'h01);
    check("mid_rst_ac_add", ac_add, 0);
    check("mid_rst_strobes", dut_s, 0);
    check("mid_rst_i_flag", i_flag, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(16'h1234, 1'b0, 6);
    check("post_rst_T0", hT[0], 8'h01);
    check("post_rst_ac_add", hs[5].ac_add, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
